// File: rtl/vga_pkg.sv
// Shared constants, opcodes and FSM state type for the VGA rectangle blitter.
// Every geometry value comes from here so the clip and counter logic agree.
package vga_pkg;

  localparam int H_RES  = 640;
  localparam int V_RES  = 480;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;

  localparam logic OP_FILL  = 1'b0;
  localparam logic OP_CLEAR = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // y*640 as two shifts so no multiplier is inferred
  function automatic logic [ADDR_W-1:0] row_base(input logic [8:0] y);
    logic [ADDR_W-1:0] y_ext;
    y_ext    = {10'd0, y};
    row_base = (y_ext << 9) + (y_ext << 7);
  endfunction

endpackage

// File: rtl/vga_rect_blitter_if.sv
// Command handshake and framebuffer write port of the blitter.
// The master side is the processor/test driver; the slave side is the blitter.
interface vga_rect_blitter_if;
  import vga_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [9:0]        cmd_x;
  logic [8:0]        cmd_y;
  logic [9:0]        cmd_w;
  logic [8:0]        cmd_h;
  logic [DATA_W-1:0] cmd_color;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] write_data;
  logic              wren_signal;
  logic              busy;
  logic              done;

  modport master (
    output cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    input  cmd_ready, write_addr, write_data, wren_signal, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    output cmd_ready, write_addr, write_data, wren_signal, busy, done
  );

endinterface

// File: rtl/vga_rect_clip.sv
// Combinational clip of a rectangle command against the visible area.
// Sums are one bit wider than the operands so they cannot wrap before clipping.
module vga_rect_clip
  import vga_pkg::*;
(
  input  logic       op_i,
  input  logic [9:0] x_i,
  input  logic [8:0] y_i,
  input  logic [9:0] w_i,
  input  logic [8:0] h_i,
  output logic [9:0] x0_o,
  output logic [8:0] y0_o,
  output logic [9:0] x_end_o,
  output logic [8:0] y_end_o,
  output logic       empty_o
);

  logic [10:0] x_sum_s;
  logic [9:0]  y_sum_s;

  assign x_sum_s = {1'b0, x_i} + {1'b0, w_i};
  assign y_sum_s = {1'b0, y_i} + {1'b0, h_i};

  // CLEAR overrides the operands with the full screen and is never empty
  always_comb begin
    x0_o    = x_i;
    y0_o    = y_i;
    x_end_o = 10'(H_RES);
    y_end_o = 9'(V_RES);
    empty_o = 1'b0;
    if (op_i == OP_CLEAR) begin
      x0_o    = 10'd0;
      y0_o    = 9'd0;
      x_end_o = 10'(H_RES);
      y_end_o = 9'(V_RES);
      empty_o = 1'b0;
    end else begin
      if (x_sum_s > 11'(H_RES)) begin
        x_end_o = 10'(H_RES);
      end else begin
        x_end_o = x_sum_s[9:0];
      end
      if (y_sum_s > 10'(V_RES)) begin
        y_end_o = 9'(V_RES);
      end else begin
        y_end_o = y_sum_s[8:0];
      end
      empty_o = (x_i >= 10'(H_RES)) || (y_i >= 9'(V_RES)) ||
                (w_i == 10'd0) || (h_i == 9'd0);
    end
  end

endmodule

// File: rtl/vga_rect_blitter.sv
// Fill-rectangle / clear-screen engine writing one colour index per clock
// into the 640x480 linear framebuffer of the VGA controller.
module vga_rect_blitter
  import vga_pkg::*;
(
  input  logic               iVGA_CLK,
  input  logic               iRST_n,
  vga_rect_blitter_if.slave  bus
);

  state_t            state_q, state_d;
  logic              op_q, op_d;
  logic [9:0]        x_q, x_d;
  logic [8:0]        y_q, y_d;
  logic [9:0]        w_q, w_d;
  logic [8:0]        h_q, h_d;
  logic [9:0]        x0_q, x0_d;
  logic [9:0]        xend_q, xend_d;
  logic [8:0]        yend_q, yend_d;
  logic [9:0]        col_q, col_d;
  logic [8:0]        row_q, row_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wren_q, wren_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              accept_s;
  logic [9:0]        clip_x0_s;
  logic [8:0]        clip_y0_s;
  logic [9:0]        clip_xend_s;
  logic [8:0]        clip_yend_s;
  logic              clip_empty_s;
  logic [ADDR_W-1:0] clip_base_s;

  vga_rect_clip u_clip (
    .op_i    (op_q),
    .x_i     (x_q),
    .y_i     (y_q),
    .w_i     (w_q),
    .h_i     (h_q),
    .x0_o    (clip_x0_s),
    .y0_o    (clip_y0_s),
    .x_end_o (clip_xend_s),
    .y_end_o (clip_yend_s),
    .empty_o (clip_empty_s)
  );

  assign clip_base_s = row_base(clip_y0_s);
  assign accept_s    = bus.cmd_valid && (state_q == IDLE);

  assign bus.cmd_ready   = (state_q == IDLE);
  // busy covers the accept cycle itself, before busy_q can rise
  assign bus.busy        = busy_q | accept_s;
  assign bus.write_addr  = addr_q;
  assign bus.write_data  = data_q;
  assign bus.wren_signal = wren_q;
  assign bus.done        = done_q;

  // State, operand, counter and output registers
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= IDLE;
      op_q    <= OP_FILL;
      x_q     <= 10'd0;
      y_q     <= 9'd0;
      w_q     <= 10'd0;
      h_q     <= 9'd0;
      x0_q    <= 10'd0;
      xend_q  <= 10'd0;
      yend_q  <= 9'd0;
      col_q   <= 10'd0;
      row_q   <= 9'd0;
      base_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      x_q     <= x_d;
      y_q     <= y_d;
      w_q     <= w_d;
      h_q     <= h_d;
      x0_q    <= x0_d;
      xend_q  <= xend_d;
      yend_q  <= yend_d;
      col_q   <= col_d;
      row_q   <= row_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and output decode; col_q/row_q always name the pixel on the bus
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    x_d     = x_q;
    y_d     = y_q;
    w_d     = w_q;
    h_d     = h_q;
    x0_d    = x0_q;
    xend_d  = xend_q;
    yend_d  = yend_q;
    col_d   = col_q;
    row_d   = row_q;
    base_d  = base_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wren_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_s) begin
          op_d    = bus.cmd_op;
          x_d     = bus.cmd_x;
          y_d     = bus.cmd_y;
          w_d     = bus.cmd_w;
          h_d     = bus.cmd_h;
          data_d  = bus.cmd_color;
          busy_d  = 1'b1;
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (clip_empty_s) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          x0_d    = clip_x0_s;
          xend_d  = clip_xend_s;
          yend_d  = clip_yend_s;
          col_d   = clip_x0_s;
          row_d   = clip_y0_s;
          base_d  = clip_base_s;
          addr_d  = clip_base_s + {9'd0, clip_x0_s};
          wren_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (col_q == (xend_q - 10'd1)) begin
          if (row_q == (yend_q - 9'd1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            col_d  = x0_q;
            row_d  = row_q + 9'd1;
            base_d = base_q + ADDR_W'(H_RES);
            addr_d = base_q + ADDR_W'(H_RES) + {9'd0, x0_q};
            wren_d = 1'b1;
          end
        end else begin
          col_d  = col_q + 10'd1;
          addr_d = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          wren_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule
